// File: rtl/edubos5_pkg.sv
// Shared types and constants for the edubos5 core and its register-file slice.
// Imported by edubos5_rf and edubos5_rf_ctrl.
package edubos5_pkg;

  localparam int XLEN        = 32;
  localparam int HI          = XLEN - 1;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;

  typedef logic [HI:0]          cpu_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  typedef enum logic [1:0] {
    RFC_INIT,
    RFC_RUN,
    RFC_DBG
  } rf_ctrl_state_t;

endpackage

// File: rtl/edubos5_rf.sv
// Register file with one synchronous write port and one asynchronous read port (rs1).
// Holds no reset; edubos5_rf_ctrl clears it after reset.
module edubos5_rf
  import edubos5_pkg::*;
(
  input  logic      clk,
  input  logic      rf_we,
  input  rf_addr_t  rf_addr,
  input  cpu_data_t rf_wdat,
  input  rf_addr_t  rs1_addr,
  output cpu_data_t rs1
);

  cpu_data_t mem [RF_NUM_REGS];

  always_ff @(posedge clk) begin
    if (rf_we) begin
      mem[rf_addr] <= rf_wdat;
    end
  end

  assign rs1 = mem[rs1_addr];

endmodule

// File: rtl/edubos5_rf_ctrl.sv
// Register-file sequencer/arbiter: clears the RF after reset, then forwards core writeback.
// With EDUBOS5_RF_DBG_EN defined, a debug host shares the RF write and rs1 ports.
module edubos5_rf_ctrl
  import edubos5_pkg::*;
#(
  parameter int        NUM_REGS     = RF_NUM_REGS,
  parameter int        DBG_MAX_WAIT = 4,
  parameter cpu_data_t INIT_VAL     = 32'h0
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      core_we,
  input  rf_addr_t  core_addr,
  input  cpu_data_t core_wdat,
  input  rf_addr_t  core_rs1_addr,
  output logic      core_stall,
  output logic      init_done,
  output logic      rf_we,
  output rf_addr_t  rf_addr,
  output cpu_data_t rf_wdat,
  output rf_addr_t  rf_rs1_addr,
  input  cpu_data_t rf_rs1,
  input  logic      dbg_req,
  input  logic      dbg_we,
  input  rf_addr_t  dbg_addr,
  input  cpu_data_t dbg_wdat,
  output logic      dbg_ack,
  output cpu_data_t dbg_rdat
);

  localparam rf_addr_t LAST_ADDR = rf_addr_t'(NUM_REGS - 1);

  rf_ctrl_state_t state_q, state_d;
  rf_addr_t       cnt_q, cnt_d;
  logic           init_done_q, init_done_d;

`ifdef EDUBOS5_RF_DBG_EN
  localparam int                WAIT_W   = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              dbg_ack_q, dbg_ack_d;
  cpu_data_t         dbg_rdat_q, dbg_rdat_d;
  logic              grant;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdat, rf_rs1};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rf_we       = 1'b0;
    rf_addr     = core_addr;
    rf_wdat     = core_wdat;
    rf_rs1_addr = core_rs1_addr;
`ifdef EDUBOS5_RF_DBG_EN
    wait_cnt_d  = wait_cnt_q;
    dbg_ack_d   = 1'b0;
    dbg_rdat_d  = dbg_rdat_q;
    grant       = 1'b0;
`endif
    case (state_q)
      RFC_INIT: begin
        rf_we   = 1'b1;
        rf_addr = cnt_q;
        rf_wdat = (cnt_q == '0) ? '0 : INIT_VAL;
        cnt_d   = cnt_q + rf_addr_t'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = RFC_RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      RFC_RUN: begin
        rf_we = core_we && (core_addr != '0);
`ifdef EDUBOS5_RF_DBG_EN
        // A pending request may lose to core writeback only DBG_MAX_WAIT times in a row.
        grant = dbg_req && !dbg_ack_q && (!core_we || (wait_cnt_q == WAIT_MAX));
        if (grant) begin
          state_d    = RFC_DBG;
          wait_cnt_d = '0;
        end else if (dbg_req && (wait_cnt_q != WAIT_MAX)) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
`endif
      end
`ifdef EDUBOS5_RF_DBG_EN
      RFC_DBG: begin
        rf_rs1_addr = dbg_addr;
        rf_we       = dbg_we && (dbg_addr != '0);
        rf_addr     = dbg_addr;
        rf_wdat     = dbg_wdat;
        dbg_ack_d   = 1'b1;
        // rf_rs1 is sampled at the same edge that commits the write, so reads see the old value.
        dbg_rdat_d  = (dbg_addr == '0) ? '0 : rf_rs1;
        state_d     = RFC_RUN;
      end
`endif
      default: begin
        state_d = RFC_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= RFC_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
`ifdef EDUBOS5_RF_DBG_EN
      wait_cnt_q  <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdat_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
`ifdef EDUBOS5_RF_DBG_EN
      wait_cnt_q  <= wait_cnt_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdat_q  <= dbg_rdat_d;
`endif
    end
  end

  assign core_stall = (state_q != RFC_RUN);
  assign init_done  = init_done_q;

`ifdef EDUBOS5_RF_DBG_EN
  assign dbg_ack  = dbg_ack_q;
  assign dbg_rdat = dbg_rdat_q;
`else
  assign dbg_ack  = 1'b0;
  assign dbg_rdat = '0;
`endif

endmodule

// File: tb/tb_edubos5_rf_ctrl.sv
// Self-checking bench for edubos5_rf_ctrl driving a real edubos5_rf.
// Debug-port scenarios are compiled in only when EDUBOS5_RF_DBG_EN is defined.
module tb_edubos5_rf_ctrl;
  import edubos5_pkg::*;

  localparam cpu_data_t INIT_V = 32'hDEAD_BEEF;

  logic      clk = 1'b0;
  logic      arst_n = 1'b0;
  logic      core_we = 1'b0;
  rf_addr_t  core_addr = '0;
  cpu_data_t core_wdat = '0;
  rf_addr_t  core_rs1_addr = '0;
  logic      core_stall, init_done, rf_we;
  rf_addr_t  rf_addr, rf_rs1_addr;
  cpu_data_t rf_wdat, rf_rs1;
  logic      dbg_req = 1'b0;
  logic      dbg_we = 1'b0;
  rf_addr_t  dbg_addr = '0;
  cpu_data_t dbg_wdat = '0;
  logic      dbg_ack;
  cpu_data_t dbg_rdat;

  int checks = 0;
  int failures = 0;

  // Architectural view of the register file: x0 is never written after init.
  cpu_data_t model_rf [32];

  always #5 clk = ~clk;

  edubos5_rf_ctrl #(
    .NUM_REGS    (32),
    .DBG_MAX_WAIT(4),
    .INIT_VAL    (INIT_V)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdat    (core_wdat),
    .core_rs1_addr(core_rs1_addr),
    .core_stall   (core_stall),
    .init_done    (init_done),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_wdat      (rf_wdat),
    .rf_rs1_addr  (rf_rs1_addr),
    .rf_rs1       (rf_rs1),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdat     (dbg_wdat),
    .dbg_ack      (dbg_ack),
    .dbg_rdat     (dbg_rdat)
  );

  edubos5_rf u_rf (
    .clk     (clk),
    .rf_we   (rf_we),
    .rf_addr (rf_addr),
    .rf_wdat (rf_wdat),
    .rs1_addr(rf_rs1_addr),
    .rs1     (rf_rs1)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input rf_addr_t addr, input cpu_data_t wdat);
    core_we   = we;
    core_addr = addr;
    core_wdat = wdat;
  endtask

  task automatic modelInit();
    model_rf[0] = '0;
    for (int i = 1; i < 32; i++) model_rf[i] = INIT_V;
  endtask

  task automatic coreWrite(input rf_addr_t addr, input cpu_data_t data);
    applyStimulus(1'b1, addr, data);
    tick();
    applyStimulus(1'b0, '0, '0);
    if (addr != 0) model_rf[addr] = data;
  endtask

  task automatic coreRead(input rf_addr_t addr, input string tag);
    core_rs1_addr = addr;
    #1;
    checkOutput(tag, rf_rs1, model_rf[addr]);
    tick();
  endtask

  // Called just after reset release; returns one tick after the last sweep edge.
  task automatic runInitSweep(input string tag);
    int bad = 0;
    int acks = 0;
    checkOutput({tag, "_stall_at_release"}, core_stall, 1'b1);
    checkOutput({tag, "_first_addr"}, rf_addr, 0);
    checkOutput({tag, "_first_wdat"}, rf_wdat, 0);
    checkOutput({tag, "_first_we"}, rf_we, 1'b1);
    for (int i = 1; i < 32; i++) begin
      tick();
      if (core_stall !== 1'b1 || init_done !== 1'b0 || rf_we !== 1'b1) bad++;
      if (rf_addr !== rf_addr_t'(i) || rf_wdat !== INIT_V) bad++;
      if (dbg_ack !== 1'b0) acks++;
    end
    tick();
    checkOutput({tag, "_sweep_errors"}, bad, 0);
    checkOutput({tag, "_acks_in_init"}, acks, 0);
    checkOutput({tag, "_init_done"}, init_done, 1'b1);
    checkOutput({tag, "_stall_after"}, core_stall, 1'b0);
    modelInit();
  endtask

`ifdef EDUBOS5_RF_DBG_EN
  // Core idle, called just after an edge while in RUN.
  task automatic dbgAccess(input logic we, input rf_addr_t addr, input cpu_data_t wdat, input string tag);
    cpu_data_t exp_rd;
    exp_rd   = model_rf[addr];
    dbg_req  = 1'b1;
    dbg_we   = we;
    dbg_addr = addr;
    dbg_wdat = wdat;
    checkOutput({tag, "_stall_grant"}, core_stall, 1'b0);
    tick();
    checkOutput({tag, "_stall_dbg"}, core_stall, 1'b1);
    checkOutput({tag, "_ack_early"}, dbg_ack, 1'b0);
    tick();
    checkOutput({tag, "_ack"}, dbg_ack, 1'b1);
    checkOutput({tag, "_stall_once"}, core_stall, 1'b0);
    checkOutput({tag, "_rdat"}, dbg_rdat, exp_rd);
    if (we && addr != 0) model_rf[addr] = wdat;
    dbg_req = 1'b0;
    tick();
    checkOutput({tag, "_ack_pulse"}, dbg_ack, 1'b0);
    checkOutput({tag, "_rdat_hold"}, dbg_rdat, exp_rd);
  endtask
`endif

  initial begin
    rf_addr_t  a;
    rf_addr_t  b;
    cpu_data_t d;
    int        cycles;
    int        bad;

    $display("[TB] start");
    #1;
    checkOutput("rst_stall", core_stall, 1'b1);
    checkOutput("rst_init_done", init_done, 1'b0);
    checkOutput("rst_dbg_ack", dbg_ack, 1'b0);
    checkOutput("rst_dbg_rdat", dbg_rdat, 0);
    checkOutput("rst_rf_addr", rf_addr, 0);
    repeat (2) @(posedge clk);
`ifdef EDUBOS5_RF_DBG_EN
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = 5'd1;
`endif
    @(negedge clk);
    arst_n = 1'b1;
    runInitSweep("init");

`ifdef EDUBOS5_RF_DBG_EN
    // Request held through init is granted in the first RUN cycle.
    tick();
    checkOutput("init_pend_stall", core_stall, 1'b1);
    tick();
    checkOutput("init_pend_ack", dbg_ack, 1'b1);
    checkOutput("init_pend_rdat", dbg_rdat, INIT_V);
    dbg_req = 1'b0;
    tick();
    checkOutput("init_pend_ack_drop", dbg_ack, 1'b0);
    for (int i = 0; i < 32; i++) dbgAccess(1'b0, rf_addr_t'(i), '0, $sformatf("dbg_init_x%0d", i));
`endif
    for (int i = 0; i < 32; i++) coreRead(rf_addr_t'(i), $sformatf("core_init_x%0d", i));

    // Core writeback, including a dropped write to x0.
    coreWrite(5'd5, 32'h1234);
    coreRead(5'd5, "core_wr_x5");
    coreWrite(5'd0, 32'hFFFF_0000);
    coreRead(5'd0, "core_wr_x0");
`ifdef EDUBOS5_RF_DBG_EN
    dbgAccess(1'b0, 5'd5, '0, "dbg_rd_x5");
    dbgAccess(1'b0, 5'd0, '0, "dbg_rd_x0");

    dbgAccess(1'b1, 5'd7, 32'hA5A5_0001, "dbg_wr_x7");
    dbgAccess(1'b0, 5'd7, '0, "dbg_rd_x7");
    coreRead(5'd7, "core_rd_x7");
    dbgAccess(1'b1, 5'd0, 32'h5555_AAAA, "dbg_wr_x0");
    coreRead(5'd0, "core_rd_x0_after_dbg");

    // Core writing every cycle: debug wins only after four losses.
    a = 5'd9;
    b = 5'd12;
    d = $urandom;
    applyStimulus(1'b1, b, 32'h0BAD_0001);
    dbg_req  = 1'b1;
    dbg_we   = 1'b1;
    dbg_addr = a;
    dbg_wdat = d;
    cycles = 0;
    while (core_stall !== 1'b1 && cycles < 10) begin
      tick();
      cycles++;
    end
    checkOutput("forced_grant_cycles", cycles, 5);
    core_wdat = 32'h0BAD_0002;
    tick();
    checkOutput("forced_ack", dbg_ack, 1'b1);
    checkOutput("forced_rdat", dbg_rdat, model_rf[a]);
    applyStimulus(1'b0, '0, '0);
    dbg_req = 1'b0;
    model_rf[a] = d;
    model_rf[b] = 32'h0BAD_0001;
    tick();
    coreRead(b, "forced_core_drop");
    coreRead(a, "forced_dbg_write");
`endif

    // Randomised traffic against the array model.
    for (int n = 0; n < 60; n++) begin
      int unsigned op;
      a = rf_addr_t'($urandom_range(0, 31));
      d = $urandom;
`ifdef EDUBOS5_RF_DBG_EN
      op = $urandom_range(0, 3);
`else
      op = $urandom_range(0, 1);
`endif
      case (op)
        0: coreWrite(a, d);
        1: coreRead(a, $sformatf("rand_core_rd_x%0d", a));
`ifdef EDUBOS5_RF_DBG_EN
        2: dbgAccess(1'b0, a, '0, $sformatf("rand_dbg_rd_x%0d", a));
        3: dbgAccess(1'b1, a, d, $sformatf("rand_dbg_wr_x%0d", a));
`endif
        default: tick();
      endcase
    end

`ifdef EDUBOS5_RF_DBG_EN
    // Reset during the DBG cycle loses the access.
    dbg_req  = 1'b1;
    dbg_we   = 1'b1;
    dbg_addr = 5'd3;
    dbg_wdat = 32'h3333_3333;
    tick();
    checkOutput("rst_dbg_in_dbg", core_stall, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    dbg_req = 1'b0;
    checkOutput("rst_dbg_ack", dbg_ack, 1'b0);
    checkOutput("rst_dbg_init_done", init_done, 1'b0);
    checkOutput("rst_dbg_addr", rf_addr, 0);
    checkOutput("rst_dbg_rdat", dbg_rdat, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    runInitSweep("rst_dbg");
    coreRead(5'd3, "rst_dbg_x3");
    dbgAccess(1'b0, 5'd3, '0, "rst_dbg_rd_x3");
`else
    // Debug port is inert in this build.
    dbg_req  = 1'b1;
    dbg_we   = 1'b1;
    dbg_addr = 5'd3;
    dbg_wdat = 32'h3333_3333;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dbg_ack !== 1'b0 || core_stall !== 1'b0 || dbg_rdat !== '0) bad++;
    end
    checkOutput("nodbg_inert_cycles", bad, 0);
    dbg_req = 1'b0;
    coreRead(5'd3, "nodbg_x3");
`endif

    // Reset in the middle of the sweep restarts it from x0.
    coreWrite(5'd20, 32'h2020_2020);
    arst_n = 1'b0;
    #1;
    checkOutput("rst_mid_init_done", init_done, 1'b0);
    checkOutput("rst_mid_stall", core_stall, 1'b1);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (10) tick();
    checkOutput("rst_mid_cnt", rf_addr, 10);
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("rst_mid_restart_addr", rf_addr, 0);
    @(negedge clk);
    arst_n = 1'b1;
    runInitSweep("rst_mid");
    coreRead(5'd20, "rst_mid_x20");
    coreRead(5'd0, "rst_mid_x0");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
